// File: rtl/data_ram_sized_if.sv
// Request/response bundle between the datapath and the data memory.
interface data_ram_sized_if;
    logic        Request;
    logic        WriteSignal;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Ready;
    logic        ReadValid;
    logic [31:0] ReadData;
    logic        Fault;
    logic [1:0]  FaultCode;

    modport master (
        output Request, WriteSignal, Size, Unsigned, Address, WriteData,
        input  Ready, ReadValid, ReadData, Fault, FaultCode
    );

    modport slave (
        input  Request, WriteSignal, Size, Unsigned, Address, WriteData,
        output Ready, ReadValid, ReadData, Fault, FaultCode
    );
endinterface

// File: rtl/data_ram_sized.sv
// Byte-addressed MIPS data memory: byte/half/word loads and stores, post-reset clear,
// one-cycle load latency and fault reporting for misaligned/out-of-range/illegal accesses.
module data_ram_sized #(
    parameter int unsigned DEPTH_WORDS    = 128,
    parameter logic [31:0] BASE_ADDR      = '0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic             ClockInput,
    input logic             ResetInput,
    data_ram_sized_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clear_idx;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            ready;
    logic            accept;
    logic            borrow;
    logic [31:0]     off;
    logic [AW-1:0]   word;
    logic [1:0]      lane;
    logic [1:0]      fcode;
    logic [3:0]      be;
    logic [31:0]     wrep;
    logic [31:0]     rword;
    logic [7:0]      rbyte;
    logic [15:0]     rhalf;
    logic [31:0]     ldata;

    assign ready     = (state_q == IDLE);
    assign bus.Ready = ready;
    assign accept    = bus.Request && ready;

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && (!CLEAR_ON_RESET || clear_idx == AW'(DEPTH_WORDS - 1)))
            state_d = IDLE;
    end

    always_ff @(posedge ClockInput) begin
        if (!ResetInput) begin
            state_q   <= CLEAR;
            clear_idx <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR)
                clear_idx <= clear_idx + 1'b1;
        end
    end

    // 33-bit subtract: the borrow flags addresses below the base without a constant compare
    always_comb begin
        {borrow, off} = {1'b0, bus.Address} - {1'b0, BASE_ADDR};
        word  = off[AW+1:2];
        lane  = off[1:0];
        fcode = 2'd0;
        if (bus.Size == 2'd3)
            fcode = 2'd3;
        else if (borrow || off >= 32'(4 * DEPTH_WORDS))
            fcode = 2'd2;
        else if ((bus.Size == 2'd1 && lane[0]) || (bus.Size == 2'd2 && lane != 2'd0))
            fcode = 2'd1;
    end

    // Store data is replicated across lanes so only the byte enables depend on the lane
    always_comb begin
        case (bus.Size)
            2'd0: begin
                be   = 4'b0001 << lane;
                wrep = {4{bus.WriteData[7:0]}};
            end
            2'd1: begin
                be   = 4'b0011 << lane;
                wrep = {2{bus.WriteData[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wrep = bus.WriteData;
            end
        endcase
    end

    always_comb begin
        rword = mem[word];
        rbyte = rword[{lane, 3'b000} +: 8];
        rhalf = lane[1] ? rword[31:16] : rword[15:0];
        case (bus.Size)
            2'd0:    ldata = {{24{rbyte[7] & ~bus.Unsigned}}, rbyte};
            2'd1:    ldata = {{16{rhalf[15] & ~bus.Unsigned}}, rhalf};
            default: ldata = rword;
        endcase
    end

    always_ff @(posedge ClockInput) begin
        if (ResetInput) begin
            if (state_q == CLEAR && CLEAR_ON_RESET) begin
                mem[clear_idx] <= '0;
            end else if (accept && bus.WriteSignal && fcode == 2'd0) begin
                for (int unsigned i = 0; i < 4; i++)
                    if (be[i])
                        mem[word][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

    always_ff @(posedge ClockInput) begin
        if (!ResetInput) begin
            bus.ReadValid <= 1'b0;
            bus.ReadData  <= '0;
            bus.Fault     <= 1'b0;
            bus.FaultCode <= 2'd0;
        end else begin
            bus.ReadValid <= 1'b0;
            bus.Fault     <= 1'b0;
            if (accept) begin
                if (fcode != 2'd0) begin
                    bus.Fault     <= 1'b1;
                    bus.FaultCode <= fcode;
                    if (!bus.WriteSignal) begin
                        bus.ReadValid <= 1'b1;
                        bus.ReadData  <= '0;
                    end
                end else if (!bus.WriteSignal) begin
                    bus.ReadValid <= 1'b1;
                    bus.ReadData  <= ldata;
                end
            end
        end
    end
endmodule
